// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; only built with HAZARD_PERF_CNT_EN.
`ifdef HAZARD_PERF_CNT_EN
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch / memory-wait hazard controller for a 5-stage pipeline.
// Optional performance counters enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IDEX_MemRead,
    input  logic [REG_W-1:0]   IDEX_rd,
    input  logic [REG_W-1:0]   IFID_rs1,
    input  logic [REG_W-1:0]   IFID_rs2,
    input  logic               IFID_use_rs1,
    input  logic               IFID_use_rs2,
    input  logic               EX_branch_taken,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               en_IF,
    output logic               en_IFID,
    output logic               flush_IFID,
    output logic               flush_IDEX,
    output logic               PCSrc,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    state_t r_state;
    state_t w_next_state;
    logic   w_mem_busy;
    logic   w_load_use;
    logic   w_br_en;
    logic   w_lu_en;

    assign w_mem_busy = mem_req & ~mem_ready;
    assign w_load_use = IDEX_MemRead & (IDEX_rd != REG_W'(0)) &
                        ((IFID_use_rs1 & (IFID_rs1 == IDEX_rd)) |
                         (IFID_use_rs2 & (IFID_rs2 == IDEX_rd)));

    // FLUSH leaves a bubble in EX; LU_STALL already resolved the pair in ID/EX.
    assign w_br_en = EX_branch_taken & (r_state != FLUSH);
    assign w_lu_en = w_load_use & ((r_state == RUN) | (r_state == MEM_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = RUN;
        en_IF        = 1'b1;
        en_IFID      = 1'b1;
        flush_IFID   = 1'b0;
        flush_IDEX   = 1'b0;
        PCSrc        = 1'b0;
        if (rst) begin
            en_IF      = 1'b0;
            en_IFID    = 1'b0;
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
        end else if (w_mem_busy) begin
            en_IF        = 1'b0;
            en_IFID      = 1'b0;
            w_next_state = MEM_WAIT;
        end else if (w_br_en) begin
            PCSrc        = 1'b1;
            flush_IFID   = 1'b1;
            flush_IDEX   = 1'b1;
            w_next_state = FLUSH;
        end else if (w_lu_en) begin
            en_IF        = 1'b0;
            en_IFID      = 1'b0;
            flush_IDEX   = 1'b1;
            w_next_state = LU_STALL;
        end
    end

    assign state = r_state;

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (~en_IF),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (PCSrc),
        .o_cnt (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus counter/reset sequences.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int NV = 24;

    logic             clk;
    logic             rst;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_rd, IFID_rs1, IFID_rs2;
    logic             IFID_use_rs1, IFID_use_rs2;
    logic             EX_branch_taken, mem_req, mem_ready;
    logic             en_IF, en_IFID, flush_IFID, flush_IDEX, PCSrc;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_rd         (IDEX_rd),
        .IFID_rs1        (IFID_rs1),
        .IFID_rs2        (IFID_rs2),
        .IFID_use_rs1    (IFID_use_rs1),
        .IFID_use_rs2    (IFID_use_rs2),
        .EX_branch_taken (EX_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .en_IF           (en_IF),
        .en_IFID         (en_IFID),
        .flush_IFID      (flush_IFID),
        .flush_IDEX      (flush_IDEX),
        .PCSrc           (PCSrc),
        .state           (state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, mr;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br, mreq, mrdy;
        logic       eif, eifid, fifid, fidex, pcs;
        logic [1:0] nst;
    } vec_t;

    vec_t       vt[NV];
    logic [1:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic br,
                                input logic mreq, input logic mrdy,
                                input logic eif, input logic eifid, input logic fifid,
                                input logic fidex, input logic pcs, input logic [1:0] nst);
        vec_t v;
        v.rst = r; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
        v.eif = eif; v.eifid = eifid; v.fifid = fifid; v.fidex = fidex;
        v.pcs = pcs; v.nst = nst;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; IDEX_MemRead = v.mr; IDEX_rd = v.rd;
        IFID_rs1 = v.rs1; IFID_rs2 = v.rs2;
        IFID_use_rs1 = v.u1; IFID_use_rs2 = v.u2;
        EX_branch_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    // Drive one vector, check the combinational outputs, then the registered state.
    task automatic apply(input vec_t v, input string tag);
        logic [1:0] e;
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, ".en_IF"},      32'(en_IF),      32'(v.eif));
        chk({tag, ".en_IFID"},    32'(en_IFID),    32'(v.eifid));
        chk({tag, ".flush_IFID"}, 32'(flush_IFID), 32'(v.fifid));
        chk({tag, ".flush_IDEX"}, 32'(flush_IDEX), 32'(v.fidex));
        chk({tag, ".PCSrc"},      32'(PCSrc),      32'(v.pcs));
        exp_q.push_back(v.nst);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".state"}, 32'(state), 32'(e));
        end
    endtask

    initial begin
        int   sc;
        int   fc;
        logic ep;
        vec_t v;

        rst = 1'b1; IDEX_MemRead = 1'b0; IDEX_rd = '0; IFID_rs1 = '0; IFID_rs2 = '0;
        IFID_use_rs1 = 1'b0; IFID_use_rs2 = 1'b0; EX_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;

        //          rst mr rd rs1 rs2 u1 u2 br rq ry | eif eifid fifid fidex pcs nst
        vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2'd0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2'd0);
        vt[2]  = mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2'd1);
        vt[3]  = mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2'd0);
        vt[4]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2'd0);
        vt[5]  = mk(0, 1, 7, 3, 7, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0, 2'd1);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2'd0);
        vt[7]  = mk(0, 1, 9, 9, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2'd0);
        vt[8]  = mk(0, 0, 9, 9, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2'd0);
        vt[9]  = mk(0, 1, 5, 5, 0, 1, 0, 1, 0, 0,  1, 1, 1, 1, 1, 2'd2);
        vt[10] = mk(0, 1, 5, 5, 0, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 2'd0);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 2'd3);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 2'd3);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 2'd3);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  1, 1, 1, 1, 1, 2'd2);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2'd3);
        vt[16] = mk(0, 1, 5, 5, 0, 1, 0, 0, 1, 1,  0, 0, 0, 1, 0, 2'd1);
        vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 1, 1, 1, 2'd2);
        vt[18] = mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2'd0);
        vt[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 2'd0);
        vt[20] = mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2'd1);
        vt[21] = mk(1, 1, 5, 5, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2'd0);
        vt[22] = mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2'd1);
        vt[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2'd0);

        for (int i = 0; i < NV; i++) begin
            apply(vt[i], $sformatf("vec%0d", i));
            if (i == 0 || i == NV - 1) begin
                chk($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt), 32'd0);
                chk($sformatf("vec%0d.flush_cnt", i), 32'(flush_cnt), 32'd0);
            end
        end

        // 20 memory-wait cycles: stall counter saturates at 15.
        sc = 0;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(v);
            #1;
            chk($sformatf("memwait%0d.en_IF", i), 32'(en_IF), 32'd0);
            @(posedge clk);
            #1;
            if (PERF && sc < 15) sc++;
            chk($sformatf("memwait%0d.stall_cnt", i), 32'(stall_cnt), 32'(sc));
        end

        // Branch held high: taken every other cycle because FLUSH masks it.
        fc = 0;
        v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 2'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            drive(v);
            #1;
            ep = ((k % 2) == 0);
            chk($sformatf("branch%0d.PCSrc", k), 32'(PCSrc), 32'(ep));
            @(posedge clk);
            #1;
            if (PERF && ep && fc < 15) fc++;
            chk($sformatf("branch%0d.flush_cnt", k), 32'(flush_cnt), 32'(fc));
        end
        chk("branch.stall_cnt_hold", 32'(stall_cnt), 32'(sc));

        // Reset in the middle of a flush, then a RUN evaluation right after.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 1, 1, 1, 2'd2), "pre_rst_flush");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 0, 2'd0), "rst_mid_flush");
        chk("rst_mid_flush.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_mid_flush.flush_cnt", 32'(flush_cnt), 32'd0);
        apply(mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2'd1), "post_rst_lu");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
